// File: rtl/reaction_timer.sv
// Racer-side reaction timer: watches the tree's stage/green lights and the launch
// button, and reports a BCD reaction time in ms, a red-light foul, or a timeout.
module reaction_timer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int MAX_MS       = 9999
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        SL,
    input  logic        G,
    input  logic        launch,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic        valid,
    output logic        foul,
    output logic        timeout,
    output logic        busy
);

    localparam int TW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);

    // MAX_MS expressed directly in BCD so the counter can be compared digit-wise
    localparam logic [15:0] MAX_BCD = {4'((MAX_MS / 1000) % 10), 4'((MAX_MS / 100) % 10),
                                       4'((MAX_MS / 10) % 10),   4'(MAX_MS % 10)};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_TIMING = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_FOUL   = 3'd4;

    logic          launch_s1_q, launch_s2_q, launch_s3_q;
    logic          sl_q, g_q;
    logic          launch_rise, sl_rise, sl_fall, g_rise;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   bcd_q, bcd_d, bcd_inc;
    logic [15:0]   time_q, time_d;
    logic          valid_q, valid_d;
    logic          foul_q, foul_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            launch_s1_q <= 1'b0;
            launch_s2_q <= 1'b0;
            launch_s3_q <= 1'b0;
            sl_q        <= 1'b0;
            g_q         <= 1'b0;
        end else begin
            launch_s1_q <= launch;
            launch_s2_q <= launch_s1_q;
            launch_s3_q <= launch_s2_q;
            sl_q        <= SL;
            g_q         <= G;
        end
    end

    assign launch_rise = launch_s2_q & ~launch_s3_q;
    assign sl_rise     = SL & ~sl_q;
    assign sl_fall     = ~SL & sl_q;
    assign g_rise      = G & ~g_q;

    // Decimal ripple increment: a digit at 9 wraps to 0 and carries onward
    always_comb begin
        logic carry;
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[i*4 +: 4] == 4'd9) begin
                    bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_inc[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bcd_d     = bcd_q;
        time_d    = time_q;
        valid_d   = valid_q;
        foul_d    = foul_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (sl_rise) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (g_rise && launch_rise) begin
                    state_d = S_DONE;
                    time_d  = 16'h0000;
                    valid_d = 1'b1;
                end else if (g_rise) begin
                    state_d = S_TIMING;
                    tick_d  = '0;
                    bcd_d   = 16'h0000;
                end else if (launch_rise) begin
                    state_d = S_FOUL;
                    time_d  = 16'h0000;
                    foul_d  = 1'b1;
                end else if (sl_fall) begin
                    state_d = S_IDLE;
                end
            end
            S_TIMING: begin
                // A launch on the cycle the limit is reached still counts as a real result
                if (launch_rise) begin
                    state_d = S_DONE;
                    time_d  = bcd_q;
                    valid_d = 1'b1;
                end else if (bcd_q == MAX_BCD) begin
                    state_d   = S_DONE;
                    time_d    = MAX_BCD;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    bcd_d  = bcd_inc;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DONE, S_FOUL: begin
                if (clear) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b0;
                    foul_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                valid_d   = 1'b0;
                foul_d    = 1'b0;
                timeout_d = 1'b0;
            end
        endcase
        busy_d = (state_d == S_ARMED) || (state_d == S_TIMING);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bcd_q     <= 16'h0000;
            time_q    <= 16'h0000;
            valid_q   <= 1'b0;
            foul_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bcd_q     <= bcd_d;
            time_q    <= time_d;
            valid_q   <= valid_d;
            foul_q    <= foul_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign time_bcd = time_q;
    assign valid    = valid_q;
    assign foul     = foul_q;
    assign timeout  = timeout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: three instances with different tick/limit
// settings; stimulus queues expected results, a monitor checks each one presented.
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SL = 1'b0, G = 1'b0, launch = 1'b0, clr = 1'b0;
    int          sel = 0;
    logic [2:0]  sl_v, g_v, ln_v;
    logic [2:0]  v, f, to, bz;
    logic [15:0] tm [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [15:0] t;
        logic        v;
        logic        f;
        logic        to;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    // Only the selected instance sees the tree/button, so idle ones never arm
    for (genvar i = 0; i < 3; i++) begin : g_gate
        assign sl_v[i] = SL && (sel == i);
        assign g_v[i]  = G && (sel == i);
        assign ln_v[i] = launch && (sel == i);
    end

    reaction_timer #(.TICKS_PER_MS(10), .MAX_MS(9999)) u0 (
        .CLOCK_50(clk), .reset(rst), .SL(sl_v[0]), .G(g_v[0]), .launch(ln_v[0]), .clear(clr),
        .time_bcd(tm[0]), .valid(v[0]), .foul(f[0]), .timeout(to[0]), .busy(bz[0]));
    reaction_timer #(.TICKS_PER_MS(2), .MAX_MS(15)) u1 (
        .CLOCK_50(clk), .reset(rst), .SL(sl_v[1]), .G(g_v[1]), .launch(ln_v[1]), .clear(clr),
        .time_bcd(tm[1]), .valid(v[1]), .foul(f[1]), .timeout(to[1]), .busy(bz[1]));
    reaction_timer #(.TICKS_PER_MS(2), .MAX_MS(9999)) u2 (
        .CLOCK_50(clk), .reset(rst), .SL(sl_v[2]), .G(g_v[2]), .launch(ln_v[2]), .clear(clr),
        .time_bcd(tm[2]), .valid(v[2]), .foul(f[2]), .timeout(to[2]), .busy(bz[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int id, input logic [15:0] t, input logic ev, input logic ef,
                        input logic eto);
        exp_t e;
        e.id = id; e.t = t; e.v = ev; e.f = ef; e.to = eto;
        q.push_back(e);
    endtask

    task automatic wait_res(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout actual pending=%0d required 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_clear(input int id);
        launch = 1'b0; G = 1'b0; SL = 1'b0;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clear_valid", {31'd0, v[id]}, 32'd0);
        chk("clear_foul", {31'd0, f[id]}, 32'd0);
        step(3);
    endtask

    task automatic arm(input int id);
        sel = id;
        SL = 1'b1;
        step(2);
        chk("armed_busy", {31'd0, bz[id]}, 32'd1);
    endtask

    // Launch k negedges after G: result = floor((k+1)/TICKS) ms given the 3-flop launch path
    task automatic race(input int id, input int k, input logic [15:0] exp_t16);
        arm(id);
        G = 1'b1;
        step(k);
        chk("timing_busy", {31'd0, bz[id]}, 32'd1);
        push(id, exp_t16, 1'b1, 1'b0, 1'b0);
        launch = 1'b1;
        wait_res(20);
        do_clear(id);
    endtask

    // Monitor: compare on every new result presented by any instance
    initial begin
        logic [2:0] prev;
        prev = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if ((v[d] | f[d]) && !prev[d]) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual dut%0d required none", d);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("res_id", d, e.id);
                        chk("res_time", {16'd0, tm[d]}, {16'd0, e.t});
                        chk("res_valid", {31'd0, v[d]}, {31'd0, e.v});
                        chk("res_foul", {31'd0, f[d]}, {31'd0, e.f});
                        chk("res_timeout", {31'd0, to[d]}, {31'd0, e.to});
                    end
                end
                prev[d] = v[d] | f[d];
            end
        end
    end

    initial begin
        step(2);
        for (int d = 0; d < 3; d++) begin
            chk("reset_flags", {28'd0, v[d], f[d], to[d], bz[d]}, 32'd0);
            chk("reset_time", {16'd0, tm[d]}, 32'd0);
        end
        rst = 1'b0;
        step(2);

        // 1: 1235 clocks at 10 ticks/ms -> 123 ms
        race(0, 1235, 16'h0123);

        // Stage abort: SL drops while armed
        arm(2);
        SL = 1'b0;
        step(1);
        chk("abort_busy", {31'd0, bz[2]}, 32'd0);
        step(2);

        // 2: red-light start, later green ignored
        arm(2);
        push(2, 16'h0000, 1'b0, 1'b1, 1'b0);
        launch = 1'b1;
        step(2);
        chk("foul_early", {31'd0, f[2]}, 32'd0);
        step(1);
        chk("foul_set", {31'd0, f[2]}, 32'd1);
        chk("foul_busy", {31'd0, bz[2]}, 32'd0);
        G = 1'b1;
        step(3);
        chk("foul_hold", {31'd0, f[2]}, 32'd1);
        chk("foul_no_valid", {31'd0, v[2]}, 32'd0);
        wait_res(2);
        do_clear(2);
        chk("idle_busy", {31'd0, bz[2]}, 32'd0);

        // 3: timeout at MAX_MS=15 with 2 ticks/ms
        arm(1);
        push(1, 16'h0015, 1'b1, 1'b0, 1'b1);
        G = 1'b1;
        step(31);
        chk("timeout_early", {31'd0, v[1]}, 32'd0);
        step(1);
        chk("timeout_valid", {31'd0, v[1]}, 32'd1);
        wait_res(5);
        do_clear(1);

        // 4: launch_rise lands on the same edge as g_rise -> 0000
        arm(2);
        push(2, 16'h0000, 1'b1, 1'b0, 1'b0);
        launch = 1'b1;
        step(2);
        G = 1'b1;
        wait_res(10);
        do_clear(2);

        // 5: decimal carry checks
        race(2, 18, 16'h0009);
        race(2, 198, 16'h0099);

        // 6: asynchronous reset mid-timing (~40 ms), then a fresh race
        arm(2);
        G = 1'b1;
        step(80);
        chk("pre_reset_busy", {31'd0, bz[2]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_flags", {28'd0, v[2], f[2], to[2], bz[2]}, 32'd0);
        chk("async_rst_time", {16'd0, tm[2]}, 32'd0);
        step(1);
        rst = 1'b0;
        G = 1'b0; SL = 1'b0; launch = 1'b0;
        step(3);
        race(2, 10, 16'h0005);

        step(5);
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "bench timed out");
    end

endmodule
